// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register writeback stage: reserved register
// indices, the writeback entry carried through the load buffer, and defaults.
package reg_writeback_pkg;

   localparam logic [3:0] REG_SP = 4'd13;
   localparam logic [3:0] REG_SR = 4'd14;
   localparam logic [3:0] REG_PC = 4'd15;

   localparam int DEFAULT_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [3:0]  addr;
      logic [15:0] data;
   } wb_entry_t;

   // SP, SR and PC are owned by dedicated hardware and never written back here
   function automatic logic is_reserved(input logic [3:0] addr);
      return (addr == REG_SP) || (addr == REG_SR) || (addr == REG_PC);
   endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bus bundle between decode/ALU/memory and the writeback stage.
interface reg_writeback_if;

   logic        issue_valid;
   logic        issue_load;
   logic [3:0]  issue_addr;
   logic        alu_valid;
   logic [3:0]  alu_addr;
   logic [15:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [3:0]  mem_addr;
   logic [15:0] mem_data;
   logic [3:0]  rd_addr1;
   logic [3:0]  rd_addr2;
   logic        hazard;
   logic        bank_busy;
   logic        write_en;
   logic [3:0]  write_addr;
   logic [15:0] write_data;
   logic        illegal_wb;

   modport master (
      output issue_valid, issue_load, issue_addr,
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output rd_addr1, rd_addr2,
      input  mem_ready, hazard, bank_busy,
      input  write_en, write_addr, write_data, illegal_wb
   );

   modport slave (
      input  issue_valid, issue_load, issue_addr,
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  rd_addr1, rd_addr2,
      output mem_ready, hazard, bank_busy,
      output write_en, write_addr, write_data, illegal_wb
   );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Synchronous load-result buffer with count-based full/empty; also reports
// whether any buffered entry targets the lower register bank (r0-r7).
module wb_fifo
   import reg_writeback_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
)(
   input  logic      clock,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic      empty,
   output logic      full,
   output logic      has_low_addr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        slots [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is only legal when the head leaves the same cycle
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slots[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) slots[wr_ptr] <= push_entry;
   end

   always_comb begin
      has_low_addr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) && !slots[rd_ptr + PTR_W'(i)].addr[3]) has_low_addr = 1'b1;
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: ALU results win, loads are buffered or
// bypassed, and a per-register outstanding-load count drives decode stalls.
module reg_writeback
   import reg_writeback_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
)(
   input  logic           clock,
   input  logic           reset,
   reg_writeback_if.slave bus
);

   wb_entry_t   alu_entry;
   wb_entry_t   mem_entry;
   wb_entry_t   head_entry;
   wb_entry_t   sel_entry;
   logic        fifo_empty;
   logic        fifo_full;
   logic        fifo_low;
   logic        mem_ready;
   logic        mem_accept;
   logic        push;
   logic        pop;
   logic        bypass;
   logic        sel_valid;
   logic        sel_load;
   logic        write_en_q;
   logic        illegal_q;
   logic        wb_load_q;
   logic [3:0]  write_addr_q;
   logic [15:0] write_data_q;
   logic [1:0]  load_cnt [16];
   logic [15:0] pending;
   logic [15:0] inc_vec;
   logic [15:0] dec_vec;

   assign alu_entry  = '{addr: bus.alu_addr, data: bus.alu_data};
   assign mem_entry  = '{addr: bus.mem_addr, data: bus.mem_data};
   assign mem_ready  = !fifo_full || !bus.alu_valid;
   assign mem_accept = bus.mem_valid && mem_ready;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) load_buf (
      .clock        (clock),
      .reset        (reset),
      .push         (push),
      .push_entry   (mem_entry),
      .pop          (pop),
      .head         (head_entry),
      .empty        (fifo_empty),
      .full         (fifo_full),
      .has_low_addr (fifo_low)
   );

   // An idle ALU slot drains the buffer head, or forwards a load straight through when empty
   always_comb begin
      pop       = !bus.alu_valid && !fifo_empty;
      bypass    = !bus.alu_valid && fifo_empty && mem_accept;
      push      = mem_accept && !bypass;
      sel_valid = bus.alu_valid || pop || bypass;
      sel_load  = pop || bypass;
      sel_entry = alu_entry;
      if (pop)         sel_entry = head_entry;
      else if (bypass) sel_entry = mem_entry;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_en_q   <= 1'b0;
         illegal_q    <= 1'b0;
         wb_load_q    <= 1'b0;
         write_addr_q <= 4'd0;
         write_data_q <= 16'd0;
      end else begin
         write_en_q <= sel_valid && !is_reserved(sel_entry.addr);
         illegal_q  <= sel_valid && is_reserved(sel_entry.addr);
         wb_load_q  <= sel_valid && sel_load && !is_reserved(sel_entry.addr);
         if (sel_valid) begin
            write_addr_q <= sel_entry.addr;
            write_data_q <= sel_entry.data;
         end
      end
   end

   // A load stays pending until the cycle its write strobe has been presented to the register file
   always_comb begin
      inc_vec = 16'd0;
      dec_vec = 16'd0;
      if (bus.issue_valid && bus.issue_load && !is_reserved(bus.issue_addr))
         inc_vec = 16'd1 << bus.issue_addr;
      if (wb_load_q)
         dec_vec = 16'd1 << write_addr_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 16; r++) load_cnt[r] <= 2'd0;
      end else begin
         for (int r = 0; r < 16; r++) begin
            if (inc_vec[r] && dec_vec[r]) begin
               if (load_cnt[r] == 2'd0) load_cnt[r] <= 2'd1;
            end else if (inc_vec[r]) begin
               load_cnt[r] <= load_cnt[r] + 2'd1;
            end else if (dec_vec[r] && (load_cnt[r] != 2'd0)) begin
               load_cnt[r] <= load_cnt[r] - 2'd1;
            end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < 16; r++) pending[r] = (load_cnt[r] != 2'd0);
   end

   assign bus.mem_ready  = mem_ready;
   assign bus.hazard     = pending[bus.rd_addr1] | pending[bus.rd_addr2];
   assign bus.bank_busy  = (|pending[7:0]) | fifo_low;
   assign bus.write_en   = write_en_q;
   assign bus.write_addr = write_addr_q;
   assign bus.write_data = write_data_q;
   assign bus.illegal_wb = illegal_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: stimulus queues expected writes, a
// negedge monitor pops and compares every write strobe or illegal pulse.
module tb_reg_writeback;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      logic        illegal;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   accepted;
   logic got;
   exp_t exp_q[$];
   exp_t mon_e;
   logic mon_ok;

   logic        ready_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [3:0]  ld_addr   [3] = '{4'd6, 4'd7, 4'd8};
   logic [15:0] ld_data   [3] = '{16'h6000, 16'h7001, 16'h8002};

   reg_writeback_if bus();

   reg_writeback #(.FIFO_DEPTH(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.issue_valid = 1'b0;
      bus.issue_load  = 1'b0;
      bus.issue_addr  = 4'd0;
      bus.alu_valid   = 1'b0;
      bus.alu_addr    = 4'd0;
      bus.alu_data    = 16'd0;
      bus.mem_valid   = 1'b0;
      bus.mem_addr    = 4'd0;
      bus.mem_data    = 16'd0;
   endtask

   task automatic drive_alu(input logic [3:0] a, input logic [15:0] d);
      bus.alu_valid = 1'b1;
      bus.alu_addr  = a;
      bus.alu_data  = d;
   endtask

   task automatic drive_mem(input logic [3:0] a, input logic [15:0] d);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = a;
      bus.mem_data  = d;
   endtask

   task automatic issue_load(input logic [3:0] a);
      bus.issue_valid = 1'b1;
      bus.issue_load  = 1'b1;
      bus.issue_addr  = a;
   endtask

   task automatic expect_write(input logic [3:0] a, input logic [15:0] d, input logic ill);
      exp_t e;
      e.addr    = a;
      e.data    = d;
      e.illegal = ill;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe or illegal pulse must match the oldest queued expectation
   always @(negedge clock) begin
      if (!reset && (bus.write_en || bus.illegal_wb)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write: got en=%0b ill=%0b addr=%0d data=0x%04h, expected no write",
                     bus.write_en, bus.illegal_wb, bus.write_addr, bus.write_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.illegal)
               mon_ok = !bus.write_en && bus.illegal_wb;
            else
               mon_ok = bus.write_en && !bus.illegal_wb &&
                        (bus.write_addr == mon_e.addr) && (bus.write_data == mon_e.data);
            if (!mon_ok) begin
               errors++;
               $display("[TB] FAIL writeback: got en=%0b ill=%0b addr=%0d data=0x%04h, expected ill=%0b addr=%0d data=0x%04h",
                        bus.write_en, bus.illegal_wb, bus.write_addr, bus.write_data,
                        mon_e.illegal, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      bus.rd_addr1 = 4'd0;
      bus.rd_addr2 = 4'd0;
      step();
      step();
      check_output("rst_write_en",   16'(bus.write_en),   16'd0);
      check_output("rst_write_addr", 16'(bus.write_addr), 16'd0);
      check_output("rst_write_data", bus.write_data,      16'd0);
      check_output("rst_illegal",    16'(bus.illegal_wb), 16'd0);
      check_output("rst_hazard",     16'(bus.hazard),     16'd0);
      check_output("rst_bank_busy",  16'(bus.bank_busy),  16'd0);
      reset = 1'b0;
      step();
      check_output("rst_mem_ready",  16'(bus.mem_ready),  16'd1);

      // ALU result, latency one
      drive_alu(4'd3, 16'h1234);
      expect_write(4'd3, 16'h1234, 1'b0);
      step();
      idle_inputs();
      check_output("alu_lat_en",   16'(bus.write_en),   16'd1);
      check_output("alu_lat_addr", 16'(bus.write_addr), 16'd3);
      check_output("alu_lat_data", bus.write_data,      16'h1234);
      step();

      // ALU and load collide: ALU first, load one cycle later
      drive_alu(4'd2, 16'hAAAA);
      drive_mem(4'd5, 16'h5555);
      #1;
      check_output("coll_ready", 16'(bus.mem_ready), 16'd1);
      expect_write(4'd2, 16'hAAAA, 1'b0);
      expect_write(4'd5, 16'h5555, 1'b0);
      step();
      idle_inputs();
      check_output("coll_first_addr", 16'(bus.write_addr), 16'd2);
      step();
      check_output("coll_second_addr", 16'(bus.write_addr), 16'd5);
      check_output("coll_second_data", bus.write_data,      16'h5555);
      step();

      // Continuous ALU traffic backpressures loads after two are buffered
      accepted = 0;
      for (int k = 0; k < 5; k++) begin
         drive_alu(4'd1, 16'h0100 + 16'(k));
         drive_mem(ld_addr[(k < 2) ? k : 2], ld_data[(k < 2) ? k : 2]);
         #1;
         check_output($sformatf("bp_ready_%0d", k), 16'(bus.mem_ready), 16'(ready_exp[k]));
         got = bus.mem_ready && bus.mem_valid;
         expect_write(4'd1, 16'h0100 + 16'(k), 1'b0);
         step();
         if (got) accepted++;
      end
      check_output("bp_accepted", 16'(accepted), 16'd2);
      bus.alu_valid = 1'b0;
      drive_mem(ld_addr[2], ld_data[2]);
      #1;
      check_output("bp_ready_drain", 16'(bus.mem_ready), 16'd1);
      for (int k = 0; k < 3; k++) expect_write(ld_addr[k], ld_data[k], 1'b0);
      step();
      idle_inputs();
      step();
      step();
      step();

      // Hazard and bank_busy on a pending load to r4
      issue_load(4'd4);
      step();
      idle_inputs();
      bus.rd_addr1 = 4'd4;
      #1;
      check_output("haz_set",  16'(bus.hazard),    16'd1);
      check_output("bank_set", 16'(bus.bank_busy), 16'd1);
      step();
      check_output("haz_hold", 16'(bus.hazard), 16'd1);
      drive_mem(4'd4, 16'h4444);
      expect_write(4'd4, 16'h4444, 1'b0);
      step();
      idle_inputs();
      check_output("haz_wr_addr",  16'(bus.write_addr), 16'd4);
      check_output("haz_at_write", 16'(bus.hazard),     16'd1);
      step();
      check_output("haz_clear",  16'(bus.hazard),    16'd0);
      check_output("bank_clear", 16'(bus.bank_busy), 16'd0);
      bus.rd_addr1 = 4'd0;

      // Two loads outstanding to r9: pending survives the first write
      issue_load(4'd9);
      step();
      issue_load(4'd9);
      step();
      idle_inputs();
      bus.rd_addr2 = 4'd9;
      #1;
      check_output("dbl_haz",  16'(bus.hazard),    16'd1);
      check_output("dbl_bank", 16'(bus.bank_busy), 16'd0);
      drive_mem(4'd9, 16'h9001);
      expect_write(4'd9, 16'h9001, 1'b0);
      step();
      idle_inputs();
      step();
      check_output("dbl_still", 16'(bus.hazard), 16'd1);
      drive_mem(4'd9, 16'h9002);
      expect_write(4'd9, 16'h9002, 1'b0);
      step();
      idle_inputs();
      step();
      check_output("dbl_clear", 16'(bus.hazard), 16'd0);
      bus.rd_addr2 = 4'd0;

      // Reserved destinations from either source
      drive_alu(4'd14, 16'hDEAD);
      expect_write(4'd14, 16'h0000, 1'b1);
      step();
      idle_inputs();
      check_output("ill_alu_en",    16'(bus.write_en),   16'd0);
      check_output("ill_alu_pulse", 16'(bus.illegal_wb), 16'd1);
      step();
      check_output("ill_alu_end",   16'(bus.illegal_wb), 16'd0);
      drive_mem(4'd15, 16'hBEEF);
      expect_write(4'd15, 16'h0000, 1'b1);
      step();
      idle_inputs();
      check_output("ill_mem_pulse", 16'(bus.illegal_wb), 16'd1);
      step();
      check_output("ill_mem_end",   16'(bus.illegal_wb), 16'd0);
      issue_load(4'd13);
      step();
      idle_inputs();
      bus.rd_addr1 = 4'd13;
      #1;
      check_output("ill_never_pending", 16'(bus.hazard), 16'd0);

      // Reset with two buffered loads and r0/r4 pending
      bus.rd_addr1 = 4'd0;
      bus.rd_addr2 = 4'd4;
      issue_load(4'd0);
      step();
      issue_load(4'd4);
      step();
      idle_inputs();
      drive_alu(4'd1, 16'hA001);
      drive_mem(4'd10, 16'hA010);
      expect_write(4'd1, 16'hA001, 1'b0);
      step();
      drive_alu(4'd1, 16'hB001);
      drive_mem(4'd11, 16'hB011);
      expect_write(4'd1, 16'hB001, 1'b0);
      step();
      idle_inputs();
      drive_alu(4'd1, 16'hC001);
      #1;
      check_output("pre_rst_ready",  16'(bus.mem_ready), 16'd0);
      check_output("pre_rst_hazard", 16'(bus.hazard),    16'd1);
      check_output("pre_rst_bank",   16'(bus.bank_busy), 16'd1);
      step();
      reset = 1'b1;
      idle_inputs();
      #1;
      check_output("midrst_en",     16'(bus.write_en),   16'd0);
      check_output("midrst_addr",   16'(bus.write_addr), 16'd0);
      check_output("midrst_data",   bus.write_data,      16'd0);
      check_output("midrst_ill",    16'(bus.illegal_wb), 16'd0);
      check_output("midrst_hazard", 16'(bus.hazard),     16'd0);
      check_output("midrst_bank",   16'(bus.bank_busy),  16'd0);
      step();
      step();
      reset = 1'b0;
      step();
      check_output("postrst_en",    16'(bus.write_en),  16'd0);
      check_output("postrst_ready", 16'(bus.mem_ready), 16'd1);
      repeat (4) step();

      check_output("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The module SHALL expose these parameters (name, default, meaning):
  FIFO_DEPTH, 2, load-result buffer entries (power of two, >=2)
REQ-002 The module SHALL expose these ports (name  direction  width  meaning):
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  issue_valid  in  1  instruction issued this cycle
  issue_load  in  1  issued instruction is a memory load
  issue_addr  in  4  load destination register
  alu_valid  in  1  ALU result present (no backpressure)
  alu_addr  in  4  ALU destination
  alu_data  in  16  ALU result
  mem_valid  in  1  load data present
  mem_ready  out  1  load data accepted when mem_valid&mem_ready
  mem_addr  in  4  load destination
  mem_data  in  16  load data
  rd_addr1, rd_addr2  in  4 each  source registers of the instruction in decode
  hazard  out  1  a source is pending; decode must stall
  bank_busy  out  1  any load pending to r0-r7 or buffered; SR bank change forbidden
  write_en  out  1  register-file write strobe
  write_addr  out  4  register-file write address
  write_data  out  16  register-file write data
  illegal_wb  out  1  one-cycle pulse: write to r13-r15 discarded

Function
REQ-003 Writes SHALL leave through registered outputs: write_en/addr/data update one clock after the accepted source (latency 1).
REQ-004 ALU results SHALL have priority; when alu_valid, that result is written next cycle.
REQ-005 Accepted load results SHALL enter a FIFO; FIFO head SHALL be written in any cycle with alu_valid=0.
REQ-006 mem_ready SHALL be 1 iff FIFO not full, or full and head drains this cycle (alu_valid=0).
REQ-007 When FIFO empty, alu_valid=0 and a load handshakes, load SHALL bypass FIFO (written next cycle).
REQ-008 Simultaneous ALU result and load handshake: ALU written, load enqueued; no data lost.
REQ-009 Destination 13, 14 or 15 (either source) SHALL produce write_en=0 for that slot and pulse illegal_wb for one cycle.
REQ-010 A 16-bit pending mask SHALL set bit issue_addr on issue_valid&issue_load, clear bit when that register's load is written; same-cycle set and clear of one bit resolves to set.
REQ-011 hazard SHALL be combinational: pending[rd_addr1] | pending[rd_addr2]; addr 13-15 never pending.
REQ-012 bank_busy SHALL be |pending[7:0] or FIFO non-empty with any entry addr<8.
REQ-013 A second issued load to an already-pending register SHALL keep the bit set until the later write; a 2-bit per-register outstanding count suffices (saturation is upstream's error).
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-015 On reset assertion (asynchronous): write_en=0, write_addr=0, write_data=0, illegal_wb=0, pending=0, FIFO empty; mem_ready=1 after deassertion.
REQ-016 Reset mid-operation SHALL discard buffered loads and pending state; no write_en pulse on the first post-reset edge.

Structure
REQ-017 Shared package SHALL hold: register-index constants (REG_SP=13, REG_SR=14, REG_PC=15), the writeback-entry struct {addr[3:0], data[15:0]}, and FIFO_DEPTH default.
REQ-018 The load buffer SHALL be one sub-module, wb_fifo (sync FIFO, count-based full/empty).

Verification
REQ-019 alu_valid=1, addr=3, data=0x1234 -> next cycle write_en=1, write_addr=3, write_data=0x1234.
REQ-020 Same cycle alu(2,0xAAAA) and load handshake(5,0x5555) -> cycle+1 writes r2=0xAAAA, cycle+2 writes r5=0x5555.
REQ-021 Continuous alu_valid with 3 loads offered -> mem_ready drops after 2 accepted; all loads written in order once alu_valid falls.
REQ-022 Issue load to r4, rd_addr1=4 -> hazard=1, bank_busy=1 until write of r4, then both 0 the following cycle.
REQ-023 alu_valid addr=14 -> write_en=0, illegal_wb=1 for exactly one cycle.
REQ-024 Assert reset while FIFO holds 2 entries and pending=0x0011 -> all outputs 0 immediately, no writes afterwards.
